// File: rtl/rr_arb_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_4
// Description : Four-requester round-robin arbiter with a bounded hold time.
//               A grant is held while its request stays up, for at most
//               MAX_HOLD cycles. Priority then rotates to the next requester
//               with no idle cycle between grants.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_GRANT    = 1'b1;
    localparam logic [7:0] c_MAX_HOLD = 8'(MAX_HOLD);

    logic [0:0] r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic       r_gnt_vld;
    logic [1:0] r_ptr;
    logic [7:0] r_hold_cnt;

    logic [0:0] w_state;
    logic [3:0] w_gnt;
    logic [1:0] w_gnt_id;
    logic       w_gnt_vld;
    logic [1:0] w_ptr;
    logic [7:0] w_hold_cnt;

    logic       w_rel_req;
    logic       w_rel_max;
    logic       w_release;
    logic [1:0] w_rel_ptr;
    logic [3:0] w_self;
    logic [3:0] w_masked;
    logic [2:0] w_first;
    logic [2:0] w_next;

    // Returns {found, index} of the first set bit of mask, searching from start
    // upward and wrapping. The loop runs from the far end so that the nearest
    // candidate is the last one written.
    function automatic logic [2:0] f_pick(input logic [1:0] start, input logic [3:0] mask);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Next-state, grant selection and hold counting.
    always_comb begin
        w_state    = r_state;
        w_gnt_id   = r_gnt_id;
        w_gnt_vld  = r_gnt_vld;
        w_ptr      = r_ptr;
        w_hold_cnt = r_hold_cnt;

        w_rel_req  = ~req[r_gnt_id];
        w_rel_max  = (r_hold_cnt == c_MAX_HOLD);
        w_release  = w_rel_req | w_rel_max | ~en;
        w_rel_ptr  = r_gnt_id + 2'd1;
        // A requester that dropped its line may not win the handover.
        w_self     = 4'b0001 << r_gnt_id;
        w_masked   = req & ~(w_rel_req ? w_self : 4'b0000);
        w_first    = f_pick(r_ptr, req);
        w_next     = f_pick(w_rel_ptr, w_masked);

        case (r_state)
            c_IDLE: begin
                if (en && w_first[2]) begin
                    w_state    = c_GRANT;
                    w_gnt_id   = w_first[1:0];
                    w_gnt_vld  = 1'b1;
                    w_hold_cnt = 8'd1;
                end
            end
            c_GRANT: begin
                if (!w_release) begin
                    w_hold_cnt = r_hold_cnt + 8'd1;
                end else begin
                    // Rotating past the releasing requester puts it last in
                    // line, so a MAX_HOLD release re-grants it only when alone.
                    w_ptr = w_rel_ptr;
                    if (en && w_next[2]) begin
                        w_gnt_id   = w_next[1:0];
                        w_gnt_vld  = 1'b1;
                        w_hold_cnt = 8'd1;
                    end else begin
                        w_state   = c_IDLE;
                        w_gnt_vld = 1'b0;
                    end
                end
            end
        endcase

        w_gnt = w_gnt_vld ? (4'b0001 << w_gnt_id) : 4'b0000;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_gnt      <= 4'b0000;
            r_gnt_id   <= 2'b00;
            r_gnt_vld  <= 1'b0;
            r_ptr      <= 2'b00;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_state;
            r_gnt      <= w_gnt;
            r_gnt_id   <= w_gnt_id;
            r_gnt_vld  <= w_gnt_vld;
            r_ptr      <= w_ptr;
            r_hold_cnt <= w_hold_cnt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign gnt_vld = r_gnt_vld;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_4
// Description : Self-checking bench for rr_arb_4. Two instances (MAX_HOLD 8
//               and 2) share the inputs; a cycle model pushes the expected
//               grant into a queue per instance as stimulus is applied.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] g8, g2;
    logic [1:0] id8, id2;
    logic       v8, v2;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // expected entry = {gnt[3:0], gnt_id[1:0], gnt_vld}
    logic [6:0] q8[$];
    logic [6:0] q2[$];
    logic [6:0] e8, e2;

    // model state, index 0 = MAX_HOLD 8, index 1 = MAX_HOLD 2
    logic       m_vld [2];
    logic [1:0] m_id  [2];
    logic [1:0] m_ptr [2];
    int         m_hold[2];
    int         m_max [2] = '{8, 2};

    always #5 clk = ~clk;

    rr_arb_4 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(g8), .gnt_id(id8), .gnt_vld(v8)
    );

    rr_arb_4 #(.MAX_HOLD(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(g2), .gnt_id(id2), .gnt_vld(v2)
    );

    // Every-cycle invariant: grant is one-hot or zero and vld tracks it.
    always @(negedge clk) begin
        if (chk_on) begin
            checks += 2;
            if (!($countones(g8) <= 1 && v8 === (g8 != 4'b0000))) begin
                errors++;
                $display("FAIL onehot dut8: gnt=%b vld=%b, required one-hot-or-zero with vld=(gnt!=0)", g8, v8);
            end
            if (!($countones(g2) <= 1 && v2 === (g2 != 4'b0000))) begin
                errors++;
                $display("FAIL onehot dut2: gnt=%b vld=%b, required one-hot-or-zero with vld=(gnt!=0)", g2, v2);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] pick(input logic [1:0] start, input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = (int'(start) + i) % 4;
            if (r[idx]) return {1'b1, 2'(idx)};
        end
        return 3'b000;
    endfunction

    task automatic model_step(input int k, input logic r, input logic e, input logic [3:0] rq);
        logic [2:0] p;
        logic [3:0] msk;
        logic       rel_req, rel_max;
        if (r) begin
            m_vld[k] = 1'b0; m_id[k] = 2'd0; m_ptr[k] = 2'd0; m_hold[k] = 0;
        end else if (!m_vld[k]) begin
            p = pick(m_ptr[k], rq);
            if (e && p[2]) begin
                m_vld[k] = 1'b1; m_id[k] = p[1:0]; m_hold[k] = 1;
            end
        end else begin
            rel_req = !rq[m_id[k]];
            rel_max = (m_hold[k] == m_max[k]);
            if (e && !rel_req && !rel_max) begin
                m_hold[k]++;
            end else begin
                m_ptr[k] = m_id[k] + 2'd1;
                msk = rq;
                if (rel_req) msk[m_id[k]] = 1'b0;
                p = pick(m_ptr[k], msk);
                if (e && p[2]) begin
                    m_id[k] = p[1:0]; m_hold[k] = 1;
                end else begin
                    m_vld[k] = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [6:0] model_out(input int k);
        logic [3:0] g;
        g = m_vld[k] ? (4'b0001 << m_id[k]) : 4'b0000;
        return {g, m_id[k], m_vld[k]};
    endfunction

    // Apply one cycle of stimulus, record expectations, advance past the edge.
    task automatic step(input logic r, input logic e, input logic [3:0] rq);
        rst = r; en = e; req = rq;
        model_step(0, r, e, rq);
        model_step(1, r, e, rq);
        q8.push_back(model_out(0));
        q2.push_back(model_out(1));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 4'b1111);
            e8 = q8.pop_front(); e2 = q2.pop_front();
            checks += 3;
            if ({g8, id8, v8} !== e8) begin errors++; $display("FAIL reset dut8: got %b/%0d/%b, required %b/%0d/%b", g8, id8, v8, e8[6:3], e8[2:1], e8[0]); end
            if ({g2, id2, v2} !== e2) begin errors++; $display("FAIL reset dut2: got %b/%0d/%b, required %b/%0d/%b", g2, id2, v2, e2[6:3], e2[2:1], e2[0]); end
            if ({g8, id8, v8} !== 7'b0000_00_0) begin errors++; $display("FAIL reset_zero: got %b/%0d/%b, required 0000/0/0", g8, id8, v8); end
        end
        chk_on = 1'b1;
    endtask

    task automatic test_single();
        step(1'b1, 1'b0, 4'b0000);
        void'(q8.pop_front()); void'(q2.pop_front());
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 4'b0100);
            e8 = q8.pop_front(); e2 = q2.pop_front();
            checks += 3;
            if ({g8, id8, v8} !== e8) begin errors++; $display("FAIL single dut8 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g8, id8, v8, e8[6:3], e8[2:1], e8[0]); end
            if ({g2, id2, v2} !== e2) begin errors++; $display("FAIL single dut2 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g2, id2, v2, e2[6:3], e2[2:1], e2[0]); end
            if (g8 !== 4'b0100 || id8 !== 2'd2) begin errors++; $display("FAIL single_const cyc%0d: got gnt=%b id=%0d, required gnt=0100 id=2", i, g8, id8); end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] seq [10];
        seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
        step(1'b1, 1'b0, 4'b0000);
        void'(q8.pop_front()); void'(q2.pop_front());
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 4'b1111);
            e8 = q8.pop_front(); e2 = q2.pop_front();
            checks += 3;
            if ({g8, id8, v8} !== e8) begin errors++; $display("FAIL fair dut8 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g8, id8, v8, e8[6:3], e8[2:1], e8[0]); end
            if ({g2, id2, v2} !== e2) begin errors++; $display("FAIL fair dut2 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g2, id2, v2, e2[6:3], e2[2:1], e2[0]); end
            if (g2 !== seq[i]) begin errors++; $display("FAIL fair_seq cyc%0d: got gnt=%b, required %b", i, g2, seq[i]); end
        end
    endtask

    task automatic test_early_release_wrap();
        logic [3:0] rq  [4];
        logic [3:0] exg [4];
        rq  = '{4'b1000, 4'b0001, 4'b0011, 4'b0010};
        exg = '{4'b1000, 4'b0001, 4'b0001, 4'b0010};
        step(1'b1, 1'b0, 4'b0000);
        void'(q8.pop_front()); void'(q2.pop_front());
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, rq[i]);
            e8 = q8.pop_front(); e2 = q2.pop_front();
            checks += 3;
            if ({g8, id8, v8} !== e8) begin errors++; $display("FAIL wrap dut8 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g8, id8, v8, e8[6:3], e8[2:1], e8[0]); end
            if ({g2, id2, v2} !== e2) begin errors++; $display("FAIL wrap dut2 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g2, id2, v2, e2[6:3], e2[2:1], e2[0]); end
            if (g8 !== exg[i]) begin errors++; $display("FAIL wrap_const cyc%0d: got gnt=%b, required %b", i, g8, exg[i]); end
        end
    endtask

    task automatic test_enable_empty();
        // {en, req, expected dut8 gnt}
        logic [8:0] tbl [9];
        tbl = '{{1'b0, 4'b1111, 4'b0000}, {1'b0, 4'b1111, 4'b0000}, {1'b0, 4'b1111, 4'b0000},
                {1'b1, 4'b1111, 4'b0001}, {1'b0, 4'b1111, 4'b0000}, {1'b1, 4'b0010, 4'b0010},
                {1'b1, 4'b0010, 4'b0010}, {1'b1, 4'b0000, 4'b0000}, {1'b1, 4'b0000, 4'b0000}};
        step(1'b1, 1'b0, 4'b0000);
        void'(q8.pop_front()); void'(q2.pop_front());
        for (int i = 0; i < 9; i++) begin
            step(1'b0, tbl[i][8], tbl[i][7:4]);
            e8 = q8.pop_front(); e2 = q2.pop_front();
            checks += 3;
            if ({g8, id8, v8} !== e8) begin errors++; $display("FAIL enable dut8 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g8, id8, v8, e8[6:3], e8[2:1], e8[0]); end
            if ({g2, id2, v2} !== e2) begin errors++; $display("FAIL enable dut2 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g2, id2, v2, e2[6:3], e2[2:1], e2[0]); end
            if (g8 !== tbl[i][3:0]) begin errors++; $display("FAIL enable_const cyc%0d: got gnt=%b, required %b", i, g8, tbl[i][3:0]); end
        end
    endtask

    task automatic test_reset_mid();
        // {rst, req, expected dut8 gnt}
        logic [8:0] tbl [4];
        tbl = '{{1'b0, 4'b1000, 4'b1000}, {1'b1, 4'b1000, 4'b0000},
                {1'b0, 4'b1001, 4'b0001}, {1'b0, 4'b1001, 4'b0001}};
        step(1'b1, 1'b0, 4'b0000);
        void'(q8.pop_front()); void'(q2.pop_front());
        for (int i = 0; i < 4; i++) begin
            step(tbl[i][8], 1'b1, tbl[i][7:4]);
            e8 = q8.pop_front(); e2 = q2.pop_front();
            checks += 3;
            if ({g8, id8, v8} !== e8) begin errors++; $display("FAIL rstmid dut8 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g8, id8, v8, e8[6:3], e8[2:1], e8[0]); end
            if ({g2, id2, v2} !== e2) begin errors++; $display("FAIL rstmid dut2 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g2, id2, v2, e2[6:3], e2[2:1], e2[0]); end
            if (g8 !== tbl[i][3:0]) begin errors++; $display("FAIL rstmid_const cyc%0d: got gnt=%b, required %b", i, g8, tbl[i][3:0]); end
        end
    endtask

    task automatic test_random();
        logic       r, e;
        logic [3:0] rq;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            e  = ($urandom_range(0, 7) != 0);
            rq = 4'($urandom_range(0, 15));
            step(r, e, rq);
            e8 = q8.pop_front(); e2 = q2.pop_front();
            checks += 2;
            if ({g8, id8, v8} !== e8) begin errors++; $display("FAIL random dut8 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g8, id8, v8, e8[6:3], e8[2:1], e8[0]); end
            if ({g2, id2, v2} !== e2) begin errors++; $display("FAIL random dut2 cyc%0d: got %b/%0d/%b, required %b/%0d/%b", i, g2, id2, v2, e2[6:3], e2[2:1], e2[0]); end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_early_release_wrap();
        test_enable_empty();
        test_reset_mid();
        test_random();
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
